sd_cmd_engine: RTL

Command-line engine for the SD card interface. It sits directly downstream of the card-initialisation FSM. It takes a command index and 32-bit argument and builds the 48-bit SD command frame, including CRC7. It serialises the frame on the CMD line at the SD bit rate, then optionally captures and checks a 48-bit response (R1/R3/R6/R7 format), returning it to the FSM with done, timeout and CRC-error status.

---
 rtl/sd_cmd_engine.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: builds the 48-bit SD command frame (with CRC7), shifts it
// out on the CMD line at the tick rate, then optionally captures and checks
// the 48-bit card response for the card-initialisation FSM.
module sd_cmd_engine #(
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        start_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  input  logic        resp_expected_i,
  input  logic        resp_crc_chk_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        resp_timeout_o,
  output logic        resp_crc_err_o,
  output logic [47:0] resp_data_o,
  output logic        cmd_out_o,
  output logic        cmd_oe_o,
  input  logic        cmd_in_i
);

  localparam int TO_W = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_WAIT,
    S_RX,
    S_FIN
  } state_t;

  // CRC7 (x^7 + x^3 + 1, init 0) over 40 bits, MSB first
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  state_t            state_q, state_d;
  logic [47:0]       frame_q, frame_d;
  logic [5:0]        bitCnt_q, bitCnt_d;
  logic [TO_W-1:0]   toCnt_q, toCnt_d;
  logic [47:0]       respData_q, respData_d;
  logic              respTimeout_q, respTimeout_d;
  logic              respCrcErr_q, respCrcErr_d;
  logic              respExp_q, respExp_d;
  logic              crcChk_q, crcChk_d;
  logic              cmdOut_q, cmdOut_d;
  logic              cmdOe_q, cmdOe_d;
  logic [39:0]       header;

  assign header = {2'b01, cmd_index_i, cmd_arg_i};

  // State and datapath registers; reset releases the CMD line immediately
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      frame_q       <= '0;
      bitCnt_q      <= '0;
      toCnt_q       <= '0;
      respData_q    <= '0;
      respTimeout_q <= 1'b0;
      respCrcErr_q  <= 1'b0;
      respExp_q     <= 1'b0;
      crcChk_q      <= 1'b0;
      cmdOut_q      <= 1'b1;
      cmdOe_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      bitCnt_q      <= bitCnt_d;
      toCnt_q       <= toCnt_d;
      respData_q    <= respData_d;
      respTimeout_q <= respTimeout_d;
      respCrcErr_q  <= respCrcErr_d;
      respExp_q     <= respExp_d;
      crcChk_q      <= crcChk_d;
      cmdOut_q      <= cmdOut_d;
      cmdOe_q       <= cmdOe_d;
    end
  end

  // Next-state logic: all CMD-line activity advances only on tick cycles
  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    bitCnt_d      = bitCnt_q;
    toCnt_d       = toCnt_q;
    respData_d    = respData_q;
    respTimeout_d = respTimeout_q;
    respCrcErr_d  = respCrcErr_q;
    respExp_d     = respExp_q;
    crcChk_d      = crcChk_q;
    cmdOut_d      = cmdOut_q;
    cmdOe_d       = cmdOe_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          frame_d       = {header, crc7(header), 1'b1};
          bitCnt_d      = '0;
          toCnt_d       = '0;
          respData_d    = '0;
          respTimeout_d = 1'b0;
          respCrcErr_d  = 1'b0;
          respExp_d     = resp_expected_i;
          crcChk_d      = resp_crc_chk_i;
          state_d       = S_TX;
        end
      end

      S_TX: begin
        if (tick_i) begin
          if (bitCnt_q == 6'd48) begin
            cmdOe_d  = 1'b0;
            cmdOut_d = 1'b1;
            bitCnt_d = '0;
            state_d  = respExp_q ? S_WAIT : S_FIN;
          end else begin
            cmdOe_d  = 1'b1;
            cmdOut_d = frame_q[47];
            frame_d  = {frame_q[46:0], 1'b1};
            bitCnt_d = bitCnt_q + 6'd1;
          end
        end
      end

      S_WAIT: begin
        if (tick_i) begin
          if (!cmd_in_i) begin
            respData_d = {respData_q[46:0], cmd_in_i};
            bitCnt_d   = 6'd1;
            state_d    = S_RX;
          end else if (toCnt_q >= TO_W'(RESP_TIMEOUT - 1)) begin
            toCnt_d       = TO_W'(RESP_TIMEOUT);
            respTimeout_d = 1'b1;
            state_d       = S_FIN;
          end else begin
            toCnt_d = toCnt_q + 1'b1;
          end
        end
      end

      S_RX: begin
        if (tick_i) begin
          respData_d = {respData_q[46:0], cmd_in_i};
          bitCnt_d   = bitCnt_q + 6'd1;
          if (bitCnt_q == 6'd47) begin
            bitCnt_d     = '0;
            state_d      = S_FIN;
            respCrcErr_d = !respData_d[0] ||
                           (crcChk_q && (respData_d[7:1] != crc7(respData_d[47:8])));
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o         = (state_q == S_TX) || (state_q == S_WAIT) || (state_q == S_RX);
  assign done_o         = (state_q == S_FIN);
  assign resp_timeout_o = respTimeout_q;
  assign resp_crc_err_o = respCrcErr_q;
  assign resp_data_o    = respData_q;
  assign cmd_out_o      = cmdOut_q;
  assign cmd_oe_o       = cmdOe_q;

endmodule
